// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
//
// Drives the board LED bar with one of four display patterns: off, bouncing
// scan, bar fill/drain, or blink. All logic runs in the slow_clock domain.
// A programmable prescaler sets the step rate. Pattern changes use a
// valid/ready handshake and take effect only at a pattern-cycle boundary,
// so a sweep is never cut off partway through.
//
// Parameters
//   NUM_LEDS   number of LEDs driven (2..15)
//   DIV_WIDTH  width of step_div and of the prescaler
//
// Ports
//   slow_clock  in   clock
//   resetn      in   asynchronous, active-low reset
//   req_valid   in   pattern change request
//   req_mode    in   requested mode: 0=IDLE 1=SCAN 2=FILL 3=BLINK
//   req_ready   out  request is accepted this cycle if req_valid is also high
//   step_div    in   pattern steps once every step_div+1 cycles (sampled live)
//   pause       in   freezes the prescaler and the pattern
//   leds        out  registered LED drive, bit0 = LED0
//   cycle_done  out  registered 1-cycle pulse after each completed pattern cycle
// ---------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int NUM_LEDS  = 10,
  parameter int DIV_WIDTH = 4
) (
  input  logic                 slow_clock,
  input  logic                 resetn,
  input  logic                 req_valid,
  input  logic [1:0]           req_mode,
  output logic                 req_ready,
  input  logic [DIV_WIDTH-1:0] step_div,
  input  logic                 pause,
  output logic [NUM_LEDS-1:0]  leds,
  output logic                 cycle_done
);

  localparam int POS_W = $clog2(NUM_LEDS + 1);

  localparam logic [POS_W-1:0] POS_ONE       = POS_W'(1);
  localparam logic [POS_W-1:0] POS_LAST_SCAN = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] POS_LAST_FILL = POS_W'(NUM_LEDS);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e                mode_q,  mode_d;
  logic [POS_W-1:0]     pos_q,   pos_d;
  dir_e                 dir_q,   dir_d;
  logic                 phase_q, phase_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [NUM_LEDS-1:0]  leds_q,  leds_d;
  logic                 cycle_done_q, cycle_done_d;

  logic tick;
  logic at_cycle_end;
  logic end_tick;
  logic accept;

  // LED image for a given pattern position. Used on the next-state values so
  // that leds is a plain register with no input-to-output path.
  function automatic logic [NUM_LEDS-1:0] leds_for(mode_e m, logic [POS_W-1:0] p, logic ph);
    logic [NUM_LEDS-1:0] v;
    v = '0;
    case (m)
      MODE_SCAN: begin
        for (int i = 0; i < NUM_LEDS; i++) v[i] = (p == POS_W'(i));
      end
      MODE_FILL: begin
        for (int i = 0; i < NUM_LEDS; i++) v[i] = (POS_W'(i) < p);
      end
      MODE_BLINK: v = {NUM_LEDS{ph}};
      default:    v = '0;
    endcase
    return v;
  endfunction

  assign tick = (presc_q == step_div) && !pause && (mode_q != MODE_IDLE);

  // The last step of a cycle is the descent 1->0 for SCAN/FILL, and the
  // on->off transition for BLINK.
  always_comb begin
    case (mode_q)
      MODE_SCAN, MODE_FILL: at_cycle_end = (pos_q == POS_ONE) && (dir_q == DIR_DOWN);
      MODE_BLINK:           at_cycle_end = phase_q;
      default:              at_cycle_end = 1'b0;
    endcase
  end

  assign end_tick  = tick && at_cycle_end;
  assign req_ready = (mode_q == MODE_IDLE) || end_tick;
  assign accept    = req_valid && req_ready;

  always_comb begin
    logic [POS_W-1:0] limit;
    // NOTE: every next-state signal gets a default here so no path through
    // this block can leave it unassigned and infer a latch.
    mode_d       = mode_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    phase_d      = phase_q;
    presc_d      = presc_q;
    cycle_done_d = end_tick;
    limit        = (mode_q == MODE_SCAN) ? POS_LAST_SCAN : POS_LAST_FILL;

    if (accept) begin
      // A request landing on end_tick replaces the step the old pattern
      // would have taken.
      mode_d  = mode_e'(req_mode);
      pos_d   = '0;
      dir_d   = DIR_UP;
      phase_d = 1'b0;
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
      case (mode_q)
        MODE_SCAN, MODE_FILL: begin
          // Direction flips on arrival at an end so that the 1->0 descent is
          // always seen with dir=down, even for a two-LED bar.
          if (dir_q == DIR_UP) begin
            pos_d = pos_q + POS_ONE;
            if (pos_q + POS_ONE == limit) dir_d = DIR_DOWN;
          end else begin
            pos_d = pos_q - POS_ONE;
            if (pos_q == POS_ONE) dir_d = DIR_UP;
          end
        end
        MODE_BLINK: phase_d = ~phase_q;
        default: ;
      endcase
    end else if (!pause && (mode_q != MODE_IDLE)) begin
      // Free-running wrap lets a live step_div drop below the count safely.
      presc_d = presc_q + DIV_WIDTH'(1);
    end

    leds_d = leds_for(mode_d, pos_d, phase_d);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge slow_clock or negedge resetn) begin
    if (!resetn) begin
      mode_q       <= MODE_IDLE;
      pos_q        <= '0;
      dir_q        <= DIR_UP;
      phase_q      <= 1'b0;
      presc_q      <= '0;
      leds_q       <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      presc_q      <= presc_d;
      leds_q       <= leds_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign leds       = leds_q;
  assign cycle_done = cycle_done_q;

endmodule
